// File: rtl/lfp_e4m4_dot_accum_if.sv
// Purpose: product-stream and result handshake bundle for lfp_e4m4_dot_accum.
// Latency: none (wires only).
// Backpressure: valid/ready on both the product stream and the result channel.
//
// Signals:
//   prod_valid/prod_ready/prod_data/prod_last : E4M4 product beats, {sign, exp[3:0], man[3:0]}
//   res_valid/res_ready                       : one result per vector
//   res_acc   : signed saturated sum, LSB weight 2^-10
//   res_count : beats accepted in the vector (saturating)
//   res_sat   : saturation occurred at least once in the vector
interface lfp_e4m4_dot_accum_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    logic             prod_valid;
    logic             prod_ready;
    logic [8:0]       prod_data;
    logic             prod_last;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_acc;
    logic [CNT_W-1:0] res_count;
    logic             res_sat;

    // Upstream producer / downstream consumer side.
    modport master (
        output prod_valid, prod_data, prod_last, res_ready,
        input  prod_ready, res_valid, res_acc, res_count, res_sat
    );

    // Accumulator side.
    modport slave (
        input  prod_valid, prod_data, prod_last, res_ready,
        output prod_ready, res_valid, res_acc, res_count, res_sat
    );
endinterface

// File: rtl/lfp_e4m4_dot_accum.sv
// Purpose: decode E4M4 products to signed fixed point and accumulate one vector with saturation.
// Latency: last beat accepted at edge N -> result valid after edge N+1; 1 beat/cycle within a vector.
// Backpressure: prod_ready drops after the last beat until the result handshake completes.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lfp_e4m4_dot_accum_if slave (product stream in, result out)
module lfp_e4m4_dot_accum #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lfp_e4m4_dot_accum_if.slave   bus
);

    // ACCUM: taking beats. FLUSH: stage 1 holds the last term. HOLD: result waiting.
    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    state_t state, state_nxt;

    logic                    accept;
    logic                    s1_valid;
    logic                    s1_last;
    logic signed [ACC_W-1:0] s1_term;
    logic signed [ACC_W-1:0] dec_term;
    logic [19:0]             dec_mag;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    sticky_sat;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W-1:0] sum_clamped;
    logic                    sat_now;
    logic signed [ACC_W-1:0] res_acc_q;
    logic [CNT_W-1:0]        res_count_q;
    logic                    res_sat_q;

    // FLUSH is exactly s1_valid & s1_last and HOLD is exactly res_valid,
    // so ready is simply "in ACCUM".
    assign bus.prod_ready = (state == ST_ACCUM);
    assign bus.res_valid  = (state == ST_HOLD);
    assign bus.res_acc    = res_acc_q;
    assign bus.res_count  = res_count_q;
    assign bus.res_sat    = res_sat_q;

    assign accept = bus.prod_valid & bus.prod_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCUM: if (accept && bus.prod_last) state_nxt = ST_FLUSH;
            ST_FLUSH: state_nxt = ST_HOLD;
            ST_HOLD:  if (bus.res_ready) state_nxt = ST_ACCUM;
            default:  state_nxt = ST_ACCUM;
        endcase
    end

    // Decode: value = 1.man * 2^exp in units of 2^-10 (bias 6 folded into the LSB weight).
    // exp == 0 is treated as zero regardless of sign or mantissa.
    always_comb begin
        dec_mag  = {15'd0, 1'b1, bus.prod_data[3:0]} << bus.prod_data[7:4];
        dec_term = '0;
        if (bus.prod_data[7:4] != 4'd0) begin
            dec_term = {{(ACC_W-20){1'b0}}, dec_mag};
            if (bus.prod_data[8]) dec_term = -dec_term;
        end
    end

    // One guard bit is enough: |acc| <= 2^(ACC_W-1) and |term| < 2^20.
    always_comb begin
        sum         = {acc[ACC_W-1], acc} + {s1_term[ACC_W-1], s1_term};
        sum_clamped = sum[ACC_W-1:0];
        sat_now     = 1'b0;
        if (sum > SUM_MAX) begin
            sum_clamped = SUM_MAX[ACC_W-1:0];
            sat_now     = 1'b1;
        end else if (sum < SUM_MIN) begin
            sum_clamped = SUM_MIN[ACC_W-1:0];
            sat_now     = 1'b1;
        end
        cnt_nxt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_term     <= '0;
            acc         <= '0;
            cnt         <= '0;
            sticky_sat  <= 1'b0;
            res_acc_q   <= '0;
            res_count_q <= '0;
            res_sat_q   <= 1'b0;
        end else begin
            // Stage 1
            s1_valid <= accept;
            if (accept) begin
                s1_last <= bus.prod_last;
                s1_term <= dec_term;
            end else begin
                s1_last <= 1'b0;
            end

            // Stage 2: the vector state clears on the same edge that publishes the result.
            if (s1_valid) begin
                if (s1_last) begin
                    res_acc_q   <= sum_clamped;
                    res_count_q <= cnt_nxt;
                    res_sat_q   <= sticky_sat | sat_now;
                    acc         <= '0;
                    cnt         <= '0;
                    sticky_sat  <= 1'b0;
                end else begin
                    acc         <= sum_clamped;
                    cnt         <= cnt_nxt;
                    sticky_sat  <= sticky_sat | sat_now;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfp_e4m4_dot_accum.sv
// Purpose: self-checking bench for lfp_e4m4_dot_accum (vector table + scoreboard + corner sequences).
// Latency: n/a.
// Backpressure: drives res_ready low during the hold sequence; otherwise always ready.
module tb_lfp_e4m4_dot_accum;

    localparam int ACC_W = 24;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lfp_e4m4_dot_accum_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    lfp_e4m4_dot_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string                   name;
        logic signed [ACC_W-1:0] acc;
        int                      cnt;
        logic                    sat;
    } exp_t;

    typedef struct {
        string                   name;
        logic [8:0]              p0;
        logic [8:0]              p1;
        int                      npat;
        int                      nbeats;
        logic [8:0]              last_d;
        logic signed [ACC_W-1:0] acc;
        int                      cnt;
        logic                    sat;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[11];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input string name, input logic signed [ACC_W-1:0] acc,
                            input int cnt, input logic sat);
        exp_t e;
        e.name = name;
        e.acc  = acc;
        e.cnt  = cnt;
        e.sat  = sat;
        sb_q.push_back(e);
    endtask

    // Result monitor: compare on every result handshake, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got acc %0d count %0d, expected no result",
                         $signed(bus.res_acc), bus.res_count);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_acc"},   longint'($signed(bus.res_acc)), longint'(e.acc));
                chk({e.name, "_count"}, longint'(bus.res_count),        longint'(e.cnt));
                chk({e.name, "_sat"},   longint'(bus.res_sat),          longint'(e.sat));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_beat(input logic [8:0] d, input logic last);
        int waited = 0;
        bus.prod_valid = 1'b1;
        bus.prod_data  = d;
        bus.prod_last  = last;
        @(negedge clk);
        while (!bus.prod_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.prod_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: prod_ready got 0, expected 1 within 100 cycles");
        end else begin
            @(posedge clk);
        end
        #1;
        bus.prod_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while (sb_q.size() != 0 && waited < 3000) begin
            @(posedge clk);
            waited++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_drain: pending results got %0d, expected 0", name, sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        int waited;
        logic [8:0] d;

        tbl[0]  = '{"single",      9'h060, 9'h060, 1, 1,   9'h060,  24'sd1024,     1,   1'b0};
        tbl[1]  = '{"mixed",       9'h060, 9'h168, 2, 3,   9'h000, -24'sd512,      3,   1'b0};
        tbl[2]  = '{"zeros",       9'h100, 9'h00F, 2, 3,   9'h061,  24'sd1088,     3,   1'b0};
        tbl[3]  = '{"neg_single",  9'h1E0, 9'h1E0, 1, 1,   9'h1E0, -24'sd262144,   1,   1'b0};
        tbl[4]  = '{"sat_pos",     9'h0FF, 9'h0FF, 1, 9,   9'h0FF,  24'sd8388607,  9,   1'b1};
        tbl[5]  = '{"after_sat",   9'h060, 9'h060, 1, 1,   9'h060,  24'sd1024,     1,   1'b0};
        tbl[6]  = '{"min_exact",   9'h1F0, 9'h1F0, 1, 16,  9'h1F0, -24'sd8388608,  16,  1'b0};
        tbl[7]  = '{"sat_neg",     9'h1F0, 9'h1F0, 1, 17,  9'h1F0, -24'sd8388608,  17,  1'b1};
        tbl[8]  = '{"sat_recover", 9'h0FF, 9'h0FF, 1, 10,  9'h1FF,  24'sd7372799,  10,  1'b1};
        tbl[9]  = '{"cancel",      9'h0FF, 9'h1FF, 2, 4,   9'h061,  24'sd1016896,  4,   1'b0};
        tbl[10] = '{"cnt_sat",     9'h060, 9'h060, 1, 300, 9'h060,  24'sd307200,   255, 1'b0};

        bus.prod_valid = 1'b0;
        bus.prod_data  = '0;
        bus.prod_last  = 1'b0;
        bus.res_ready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", longint'(bus.res_valid), 0);
        chk("rst_res_acc",   longint'(bus.res_acc),   0);
        chk("rst_res_count", longint'(bus.res_count), 0);
        chk("rst_res_sat",   longint'(bus.res_sat),   0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", longint'(bus.prod_ready), 1);

        // Latency: single beat accepted at edge N, result visible after edge N+1.
        push_exp("latency", 24'sd1024, 1, 1'b0);
        bus.prod_valid = 1'b1;
        bus.prod_data  = 9'h060;
        bus.prod_last  = 1'b1;
        @(negedge clk);
        chk("lat_ready_before", longint'(bus.prod_ready), 1);
        @(posedge clk);
        #1;
        bus.prod_valid = 1'b0;
        @(negedge clk);
        chk("lat_flush_valid", longint'(bus.res_valid),  0);
        chk("lat_flush_ready", longint'(bus.prod_ready), 0);
        @(negedge clk);
        chk("lat_res_valid",   longint'(bus.res_valid),  1);
        @(posedge clk);
        #1;

        // Table-driven vectors with occasional idle cycles between beats.
        for (int t = 0; t < 11; t++) begin
            push_exp(tbl[t].name, tbl[t].acc, tbl[t].cnt, tbl[t].sat);
            for (int i = 0; i < tbl[t].nbeats; i++) begin
                if (i == tbl[t].nbeats - 1)       d = tbl[t].last_d;
                else if ((i % tbl[t].npat) == 0)  d = tbl[t].p0;
                else                              d = tbl[t].p1;
                if ($urandom_range(0, 7) == 0) begin
                    @(posedge clk);
                    #1;
                end
                drive_beat(d, (i == tbl[t].nbeats - 1));
            end
        end
        drain("table");

        // Backpressure: result held while the next vector's beat waits.
        bus.res_ready = 1'b0;
        push_exp("bp_first", 24'sd1024, 1, 1'b0);
        drive_beat(9'h060, 1'b1);
        waited = 0;
        @(negedge clk);
        while (!bus.res_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("bp_res_valid", longint'(bus.res_valid), 1);
        push_exp("bp_next", 24'sd1088, 1, 1'b0);
        @(posedge clk);
        #1;
        bus.prod_valid = 1'b1;
        bus.prod_data  = 9'h061;
        bus.prod_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_prod_ready", longint'(bus.prod_ready), 0);
            chk("bp_hold_acc",   longint'($signed(bus.res_acc)), 1024);
            chk("bp_hold_count", longint'(bus.res_count), 1);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        drive_beat(9'h061, 1'b1);
        drain("bp");

        // Reset mid-vector discards the partial sum.
        drive_beat(9'h060, 1'b0);
        drive_beat(9'h060, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", longint'(bus.res_valid), 0);
        chk("midrst_res_acc",   longint'(bus.res_acc),   0);
        chk("midrst_res_count", longint'(bus.res_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp("after_rst", 24'sd1024, 1, 1'b0);
        drive_beat(9'h060, 1'b1);
        drain("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
